// File: rtl/basket_pkg.sv
`default_nettype none
// ============================================================================
// Module   : basket_pkg
// Brief    : Shared types, widths and price table for the basket controller.
// Revision : 1.0 - initial release
// ============================================================================
package basket_pkg;

    localparam int PRODUCT_ID_W = 4;
    localparam int COUNT_W      = 4;
    // Entry quantity field is sized for the default QTY_W; QTY_W must not exceed it.
    localparam int QTY_FIELD_W  = 4;
    localparam int PRICE_W      = 8;
    localparam int TOTAL_W      = 12;
    localparam int TOTAL_MAX    = 4095;

    typedef struct packed {
        logic [PRODUCT_ID_W-1:0] id;
        logic [QTY_FIELD_W-1:0]  qty;
    } basket_entry_t;

    typedef enum logic [1:0] {
        CMD_NONE   = 2'd0,
        CMD_ADD    = 2'd1,
        CMD_CANCEL = 2'd2,
        CMD_CLEAR  = 2'd3
    } basket_cmd_t;

    // Unit price per product ID, listed from ID 15 down to ID 0.
    localparam logic [15:0][PRICE_W-1:0] PRICE_TABLE = {
        8'd45, 8'd35, 8'd60, 8'd99, 8'd7,  8'd50, 8'd22, 8'd18,
        8'd5,  8'd40, 8'd8,  8'd30, 8'd25, 8'd15, 8'd12, 8'd10
    };

    function automatic logic [PRICE_W-1:0] price_of(input logic [PRODUCT_ID_W-1:0] id);
        return PRICE_TABLE[id];
    endfunction

    function automatic logic [TOTAL_W-1:0] sat_total(input logic [31:0] value);
        return (value > 32'(TOTAL_MAX)) ? TOTAL_W'(TOTAL_MAX) : value[TOTAL_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/basket_match.sv
`default_nettype none
// ============================================================================
// Module   : basket_match
// Brief    : Parallel product-ID compare over the occupied basket slots,
//            returning a hit flag and the lowest matching slot index.
// Revision : 1.0 - initial release
// ============================================================================
module basket_match
    import basket_pkg::*;
#(
    parameter int MAX_ENTRIES = 8,
    parameter int IDX_W       = $clog2(MAX_ENTRIES)
)(
    input  logic [MAX_ENTRIES-1:0][PRODUCT_ID_W-1:0] i_slot_ids,
    input  logic [COUNT_W-1:0]                       i_count,
    input  logic [PRODUCT_ID_W-1:0]                  i_id,
    output logic                                     o_hit,
    output logic [IDX_W-1:0]                         o_idx
);

    logic [MAX_ENTRIES-1:0] w_eq;

    for (genvar g = 0; g < MAX_ENTRIES; g++) begin : g_cmp
        assign w_eq[g] = (COUNT_W'(g) < i_count) && (i_slot_ids[g] == i_id);
    end

    // Scan downward so the lowest matching slot is the one that sticks.
    always_comb begin
        o_idx = '0;
        for (int i = MAX_ENTRIES - 1; i >= 0; i--) begin
            if (w_eq[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign o_hit = |w_eq;

endmodule
`default_nettype wire

// File: rtl/basket_controller.sv
`default_nettype none
// ============================================================================
// Module   : basket_controller
// Brief    : Ordered, compacted product basket with add/cancel/clear commands,
//            count reporting and a display read port.
// Options  : BASKET_TOTAL_EN enables the Total_Price running sum.
// Revision : 1.0 - initial release
// ============================================================================
module basket_controller
    import basket_pkg::*;
#(
    parameter int MAX_ENTRIES = 8,
    parameter int QTY_W       = 4,
    parameter int QTY_MAX     = 15
)(
    input  logic                           CLOCK_50,
    input  logic                           RESET,
    input  logic                           Add_Pulse,
    input  logic                           Cancel_Pulse,
    input  logic                           Clear_Pulse,
    input  logic [PRODUCT_ID_W-1:0]        ProductID_in,
    input  logic [QTY_W-1:0]               ProductQuantity_in,
    input  logic [$clog2(MAX_ENTRIES)-1:0] Rd_Index,
    output logic [PRODUCT_ID_W-1:0]        Rd_ProductID,
    output logic [QTY_W-1:0]               Rd_Quantity,
    output logic [COUNT_W-1:0]             BasketProductNum,
    output logic                           Busy,
    output logic                           Full_Err,
    output logic                           NotFound_Err,
    output logic                           Cmd_Drop,
    output logic [TOTAL_W-1:0]             Total_Price
);

    localparam int IDX_W  = $clog2(MAX_ENTRIES);
    localparam int QTY_W1 = QTY_W + 1;
    localparam logic [QTY_W:0] c_QTY_SAT = QTY_W1'(QTY_MAX);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                 r_state;
    basket_entry_t          r_slot [MAX_ENTRIES];
    logic [IDX_W-1:0]       r_ptr;
    logic [COUNT_W-1:0]     r_count;
    logic                   r_full_err;
    logic                   r_nf_err;
    logic                   r_drop;

    logic [MAX_ENTRIES-1:0][PRODUCT_ID_W-1:0] w_slot_ids;
    basket_cmd_t            w_cmd;
    logic [1:0]             w_npulse;
    logic                   w_drop;
    logic                   w_hit;
    logic [IDX_W-1:0]       w_hit_idx;
    logic [QTY_W-1:0]       w_hit_qty;
    logic [QTY_W:0]         w_sum;
    logic [QTY_W-1:0]       w_sat_qty;
    logic                   w_full;
    logic                   w_add_new;
    logic [IDX_W-1:0]       w_wr_idx;
    logic [IDX_W-1:0]       w_ptr_next;
    logic [COUNT_W-1:0]     w_last;
    logic [IDX_W-1:0]       w_last_idx;
    logic                   w_more;
    basket_entry_t          w_rd_entry;

    for (genvar g = 0; g < MAX_ENTRIES; g++) begin : g_ids
        assign w_slot_ids[g] = r_slot[g].id;
    end

    basket_match #(
        .MAX_ENTRIES (MAX_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_match (
        .i_slot_ids  (w_slot_ids),
        .i_count     (r_count),
        .i_id        (ProductID_in),
        .o_hit       (w_hit),
        .o_idx       (w_hit_idx)
    );

    // Clear beats cancel beats add; any losing pulse is reported as dropped.
    always_comb begin
        w_cmd = CMD_NONE;
        if (Clear_Pulse) begin
            w_cmd = CMD_CLEAR;
        end else if (Cancel_Pulse) begin
            w_cmd = CMD_CANCEL;
        end else if (Add_Pulse) begin
            w_cmd = CMD_ADD;
        end
    end

    assign w_npulse = {1'b0, Add_Pulse} + {1'b0, Cancel_Pulse} + {1'b0, Clear_Pulse};
    assign w_drop   = (w_npulse > 2'd1) ||
                      ((r_state == ST_SHIFT) && ((w_cmd == CMD_ADD) || (w_cmd == CMD_CANCEL)));

    assign w_hit_qty = r_slot[w_hit_idx].qty[QTY_W-1:0];
    assign w_sum     = {1'b0, w_hit_qty} + {1'b0, ProductQuantity_in};
    assign w_sat_qty = (w_sum > c_QTY_SAT) ? c_QTY_SAT[QTY_W-1:0] : w_sum[QTY_W-1:0];
    assign w_full    = (r_count == COUNT_W'(MAX_ENTRIES));
    // A zero-quantity add of a new product leaves the basket untouched.
    assign w_add_new = !w_hit && (ProductQuantity_in != '0);
    assign w_wr_idx  = IDX_W'(r_count);

    assign w_ptr_next = r_ptr + IDX_W'(1);
    assign w_last     = r_count - COUNT_W'(1);
    assign w_last_idx = IDX_W'(w_last);
    assign w_more     = (COUNT_W'(r_ptr) < w_last);

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_count    <= '0;
            r_full_err <= 1'b0;
            r_nf_err   <= 1'b0;
            r_drop     <= 1'b0;
            for (int i = 0; i < MAX_ENTRIES; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            r_full_err <= 1'b0;
            r_nf_err   <= 1'b0;
            r_drop     <= w_drop;
            if (w_cmd == CMD_CLEAR) begin
                r_state <= ST_IDLE;
                r_ptr   <= '0;
                r_count <= '0;
                for (int i = 0; i < MAX_ENTRIES; i++) begin
                    r_slot[i] <= '0;
                end
            end else if (r_state == ST_IDLE) begin
                case (w_cmd)
                    CMD_ADD: begin
                        if (w_hit) begin
                            r_slot[w_hit_idx].qty <= QTY_FIELD_W'(w_sat_qty);
                        end else if (w_add_new) begin
                            if (w_full) begin
                                r_full_err <= 1'b1;
                            end else begin
                                r_slot[w_wr_idx].id  <= ProductID_in;
                                r_slot[w_wr_idx].qty <= QTY_FIELD_W'(ProductQuantity_in);
                                r_count              <= r_count + COUNT_W'(1);
                            end
                        end
                    end
                    CMD_CANCEL: begin
                        if (w_hit) begin
                            r_ptr   <= w_hit_idx;
                            r_state <= ST_SHIFT;
                        end else begin
                            r_nf_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else begin
                // One slot of compaction per cycle; the tail slot is freed last.
                if (w_more) begin
                    r_slot[r_ptr] <= r_slot[w_ptr_next];
                    r_ptr         <= w_ptr_next;
                end else begin
                    r_slot[w_last_idx] <= '0;
                    r_count            <= w_last;
                    r_state            <= ST_IDLE;
                end
            end
        end
    end

    assign w_rd_entry       = r_slot[Rd_Index];
    assign Rd_ProductID     = w_rd_entry.id;
    assign Rd_Quantity      = (COUNT_W'(Rd_Index) < r_count) ? w_rd_entry.qty[QTY_W-1:0] : '0;
    assign BasketProductNum = r_count;
    assign Busy             = (r_state == ST_SHIFT);
    assign Full_Err         = r_full_err;
    assign NotFound_Err     = r_nf_err;
    assign Cmd_Drop         = r_drop;

`ifdef BASKET_TOTAL_EN
    logic [TOTAL_W-1:0] r_total;
    logic               r_total_sat;
    logic [31:0]        w_add_term;
    logic [31:0]        w_add_raw;
    logic [31:0]        w_rm_term;
    logic [31:0]        w_recalc;

    always_comb begin
        w_add_term = w_hit ? 32'(price_of(ProductID_in)) * 32'(w_sat_qty - w_hit_qty)
                           : 32'(price_of(ProductID_in)) * 32'(ProductQuantity_in);
        w_add_raw  = 32'(r_total) + w_add_term;
        w_rm_term  = 32'(price_of(ProductID_in)) * 32'(w_hit_qty);
        // Surviving entries occupy slots below count-1 on the final shift cycle.
        w_recalc   = '0;
        for (int i = 0; i < MAX_ENTRIES; i++) begin
            if (COUNT_W'(i) < w_last) begin
                w_recalc = w_recalc + 32'(price_of(r_slot[i].id)) * 32'(r_slot[i].qty);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET || (w_cmd == CMD_CLEAR)) begin
            r_total     <= '0;
            r_total_sat <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if ((w_cmd == CMD_ADD) && (w_hit || (w_add_new && !w_full))) begin
                r_total <= sat_total(w_add_raw);
                if (w_add_raw > 32'(TOTAL_MAX)) begin
                    r_total_sat <= 1'b1;
                end
            end else if ((w_cmd == CMD_CANCEL) && w_hit && !r_total_sat) begin
                r_total <= r_total - TOTAL_W'(w_rm_term);
            end
        end else if (!w_more && r_total_sat) begin
            r_total     <= sat_total(w_recalc);
            r_total_sat <= (w_recalc > 32'(TOTAL_MAX));
        end
    end

    assign Total_Price = r_total;
`else
    assign Total_Price = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_basket_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_basket_controller
// Brief    : Directed self-checking bench for basket_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_basket_controller;

    logic        CLOCK_50;
    logic        RESET;
    logic        Add_Pulse;
    logic        Cancel_Pulse;
    logic        Clear_Pulse;
    logic [3:0]  ProductID_in;
    logic [3:0]  ProductQuantity_in;
    logic [2:0]  Rd_Index;
    logic [3:0]  Rd_ProductID;
    logic [3:0]  Rd_Quantity;
    logic [3:0]  BasketProductNum;
    logic        Busy;
    logic        Full_Err;
    logic        NotFound_Err;
    logic        Cmd_Drop;
    logic [11:0] Total_Price;

    int n_total = 0;
    int n_bad   = 0;

    basket_controller #(
        .MAX_ENTRIES (8),
        .QTY_W       (4),
        .QTY_MAX     (15)
    ) dut (
        .CLOCK_50           (CLOCK_50),
        .RESET              (RESET),
        .Add_Pulse          (Add_Pulse),
        .Cancel_Pulse       (Cancel_Pulse),
        .Clear_Pulse        (Clear_Pulse),
        .ProductID_in       (ProductID_in),
        .ProductQuantity_in (ProductQuantity_in),
        .Rd_Index           (Rd_Index),
        .Rd_ProductID       (Rd_ProductID),
        .Rd_Quantity        (Rd_Quantity),
        .BasketProductNum   (BasketProductNum),
        .Busy               (Busy),
        .Full_Err           (Full_Err),
        .NotFound_Err       (NotFound_Err),
        .Cmd_Drop           (Cmd_Drop),
        .Total_Price        (Total_Price)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one command for exactly one edge; outputs are sampled 1ns after it.
    task automatic cmd(input logic a, input logic c, input logic k,
                       input logic [3:0] id, input logic [3:0] q);
        Add_Pulse          = a;
        Cancel_Pulse       = c;
        Clear_Pulse        = k;
        ProductID_in       = id;
        ProductQuantity_in = q;
        @(posedge CLOCK_50);
        #1;
        Add_Pulse    = 1'b0;
        Cancel_Pulse = 1'b0;
        Clear_Pulse  = 1'b0;
    endtask

    task automatic check_slot(input string tag, input int idx, input int id, input int q);
        Rd_Index = 3'(idx);
        #1;
        check({tag, "_id"}, 32'(Rd_ProductID), id);
        check({tag, "_qty"}, 32'(Rd_Quantity), q);
    endtask

    task automatic run_shift(input string tag, input int exp_cycles);
        int n = 0;
        while ((Busy === 1'b1) && (n < 20)) begin
            @(posedge CLOCK_50);
            #1;
            n++;
        end
        check(tag, n, exp_cycles);
    endtask

    initial begin
        RESET = 1'b1;
        Add_Pulse = 1'b0; Cancel_Pulse = 1'b0; Clear_Pulse = 1'b0;
        ProductID_in = '0; ProductQuantity_in = '0; Rd_Index = '0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        RESET = 1'b0;

        check("rst_count", 32'(BasketProductNum), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_flags", {29'd0, Full_Err, NotFound_Err, Cmd_Drop}, 0);
        check("rst_total", 32'(Total_Price), 0);
        check_slot("rst_slot0", 0, 0, 0);

        // Two distinct adds, each visible one cycle after its pulse
        cmd(1, 0, 0, 4'd3, 4'd2);
        check("add1_count", 32'(BasketProductNum), 1);
        check_slot("add1_slot0", 0, 3, 2);
        cmd(1, 0, 0, 4'd5, 4'd4);
        check("add2_count", 32'(BasketProductNum), 2);
        check("add2_drop", 32'(Cmd_Drop), 0);
        check_slot("add2_slot1", 1, 5, 4);
        check_slot("add2_slot0", 0, 3, 2);
        check_slot("add2_unocc", 2, 0, 0);

        // Saturating quantity merge
        cmd(0, 0, 1, 4'd0, 4'd0);
        check("clr_count", 32'(BasketProductNum), 0);
        cmd(1, 0, 0, 4'd3, 4'd9);
        check_slot("sat_a", 0, 3, 9);
        cmd(1, 0, 0, 4'd3, 4'd9);
        check_slot("sat_b", 0, 3, 15);
        cmd(1, 0, 0, 4'd3, 4'd4);
        check_slot("sat_c", 0, 3, 15);
        check("sat_count", 32'(BasketProductNum), 1);
        check("sat_fullerr", 32'(Full_Err), 0);

        // Fill to capacity, then overflow
        cmd(0, 0, 1, 4'd0, 4'd0);
        for (int i = 1; i <= 8; i++) cmd(1, 0, 0, 4'(i), 4'd1);
        check("fill_count", 32'(BasketProductNum), 8);
        cmd(1, 0, 0, 4'd12, 4'd1);
        check("full_err", 32'(Full_Err), 1);
        check("full_count", 32'(BasketProductNum), 8);
        check_slot("full_slot7", 7, 8, 1);
        @(posedge CLOCK_50);
        #1;
        check("full_err_pulse", 32'(Full_Err), 0);
        cmd(1, 0, 0, 4'd4, 4'd3);
        check("full_hit_err", 32'(Full_Err), 0);
        check_slot("full_hit", 3, 4, 4);

        // Cancel from the middle of [1,2,3,4]
        cmd(0, 0, 1, 4'd0, 4'd0);
        for (int i = 1; i <= 4; i++) cmd(1, 0, 0, 4'(i), 4'd1);
        cmd(0, 1, 0, 4'd2, 4'd0);
        check("cxl_busy", 32'(Busy), 1);
        run_shift("cxl_cycles", 3);
        check("cxl_count", 32'(BasketProductNum), 3);
        check_slot("cxl_s0", 0, 1, 1);
        check_slot("cxl_s1", 1, 3, 1);
        check_slot("cxl_s2", 2, 4, 1);
        check_slot("cxl_s3", 3, 0, 0);

        cmd(0, 1, 0, 4'd9, 4'd0);
        check("nf_err", 32'(NotFound_Err), 1);
        check("nf_busy", 32'(Busy), 0);
        @(posedge CLOCK_50);
        #1;
        check("nf_pulse", 32'(NotFound_Err), 0);

        // Commands arriving during compaction
        cmd(0, 1, 0, 4'd1, 4'd0);
        check("sh_busy", 32'(Busy), 1);
        cmd(1, 0, 0, 4'd7, 4'd1);
        check("sh_add_drop", 32'(Cmd_Drop), 1);
        check("sh_add_count", 32'(BasketProductNum), 3);
        cmd(0, 0, 1, 4'd0, 4'd0);
        check("sh_clr_count", 32'(BasketProductNum), 0);
        check("sh_clr_busy", 32'(Busy), 0);
        check("sh_clr_drop", 32'(Cmd_Drop), 0);

        // Add and cancel together: cancel wins
        cmd(1, 0, 0, 4'd6, 4'd2);
        cmd(1, 0, 0, 4'd7, 4'd1);
        cmd(1, 1, 0, 4'd6, 4'd5);
        check("ac_drop", 32'(Cmd_Drop), 1);
        check("ac_busy", 32'(Busy), 1);
        run_shift("ac_cycles", 2);
        check("ac_count", 32'(BasketProductNum), 1);
        check_slot("ac_s0", 0, 7, 1);

        // Reset in the middle of a compaction
        for (int i = 1; i <= 3; i++) cmd(1, 0, 0, 4'(i), 4'd1);
        cmd(0, 1, 0, 4'd7, 4'd0);
        @(posedge CLOCK_50);
        #1;
        check("mid_busy_pre", 32'(Busy), 1);
        RESET = 1'b1;
        @(posedge CLOCK_50);
        #1;
        RESET = 1'b0;
        check("mid_count", 32'(BasketProductNum), 0);
        check("mid_busy", 32'(Busy), 0);
        check("mid_flags", {29'd0, Full_Err, NotFound_Err, Cmd_Drop}, 0);
        check("mid_total", 32'(Total_Price), 0);
        check_slot("mid_s0", 0, 0, 0);
        check_slot("mid_s1", 1, 0, 0);

        // Running total (price of ID 3 is 25)
        cmd(1, 0, 0, 4'd3, 4'd2);
`ifdef BASKET_TOTAL_EN
        check("tot_add", 32'(Total_Price), 50);
`else
        check("tot_add", 32'(Total_Price), 0);
`endif
        cmd(0, 1, 0, 4'd3, 4'd0);
        check("tot_cxl", 32'(Total_Price), 0);
        run_shift("tot_cycles", 1);
        check("tot_count", 32'(BasketProductNum), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
